// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold / shift right / shift left / load, synchronous preset,
// and a saturating shift counter that pulses done after a full-word serialisation.
// Optional wrap-around shifting via the rotate port when UREG_ROTATE_EN is defined.
module univ_shift_reg #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             preset,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
`ifdef UREG_ROTATE_EN
   input  logic             rotate,
`endif
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             sout_r,
   output logic             sout_l,
   output logic             done
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

   logic [CW-1:0] cnt;
   logic          ins_r;
   logic          ins_l;
   logic          shifting;

   always_comb begin
      ins_r = sin_r;
      ins_l = sin_l;
`ifdef UREG_ROTATE_EN
      if (rotate) begin
         ins_r = q[0];
         ins_l = q[WIDTH-1];
      end
`endif
   end

   assign shifting = mode[0] ^ mode[1];
   assign qbar     = ~q;
   assign sout_r   = q[0];
   assign sout_l   = q[WIDTH-1];

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         q    <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (!preset) begin
         q    <= PRESET_VAL;
         cnt  <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (mode)
            2'b01:   q <= {ins_r, q[WIDTH-1:1]};
            2'b10:   q <= {q[WIDTH-2:0], ins_l};
            2'b11:   q <= d;
            default: q <= q;
         endcase
         // Counter saturates at WIDTH so done fires only on the WIDTH-1 -> WIDTH step.
         if (mode == 2'b11) begin
            cnt <= '0;
         end else if (shifting && (cnt != CNT_FULL)) begin
            cnt  <= cnt + 1'b1;
            done <= (cnt == CNT_FULL - 1'b1);
         end
      end
   end

endmodule
